// File: rtl/note_player.sv
// ---------------------------------------------------------------------------
// note_player
//   Pulls notes from the pattern sequencer and plays them on one voice.
//   Each note is timed in frame ticks (len * TICKS_PER_UNIT ticks), its pitch
//   is converted to a phase increment through an external period ROM with
//   one cycle of read latency, and a simple linear decay envelope drives the
//   4-bit volume. When a note expires, the next one is requested with a
//   single o_note_stb pulse.
//
// Ports
//   i_clk               clock
//   i_rst               synchronous active-high reset
//   i_tick              frame tick strobe (1 cycle)
//   i_enable            0 = pause, ticks are ignored
//   o_note_stb          request next note (1-cycle pulse)
//   i_note_valid        note fields valid (1-cycle pulse)
//   i_note_pitch [5:0]  pitch index, 0 = rest
//   i_note_len   [4:0]  duration in units, 0 treated as 1
//   i_note_instrument   [2:0] decay period in ticks (0 = sustain), [3] unused
//   o_pitch_rom_addr    period ROM address
//   i_pitch_rom_data    ROM data, valid one cycle after the address
//   o_phase_inc         oscillator phase increment
//   o_gate              note sounding
//   o_volume            envelope level
// ---------------------------------------------------------------------------
module note_player #(
    parameter int unsigned TICKS_PER_UNIT = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic        i_enable,
    output logic        o_note_stb,
    input  logic        i_note_valid,
    input  logic [5:0]  i_note_pitch,
    input  logic [4:0]  i_note_len,
    input  logic [3:0]  i_note_instrument,
    output logic [5:0]  o_pitch_rom_addr,
    input  logic [15:0] i_pitch_rom_data,
    output logic [15:0] o_phase_inc,
    output logic        o_gate,
    output logic [3:0]  o_volume
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_LOAD   = 3'd3,
        ST_PLAY   = 3'd4
    } state_t;

    localparam logic [7:0] TPU = 8'(TICKS_PER_UNIT);

    state_t      state_r;
    state_t      state_nxt_s;

    logic [5:0]  pitch_r;
    logic [4:0]  len_r;
    logic [2:0]  decay_per_r;
    logic [7:0]  tick_cnt_r;
    logic [4:0]  unit_cnt_r;
    logic [2:0]  decay_cnt_r;

    logic        stb_r;
    logic        gate_r;
    logic [3:0]  vol_r;
    logic [15:0] phase_r;
    logic [5:0]  addr_r;

    logic        count_s;
    logic        note_end_s;
    logic        decaying_s;
    logic        unused_instr_s;

    assign unused_instr_s = i_note_instrument[3];

    // Ticks only advance a note while playing and not paused; anything else is dropped.
    assign count_s    = (state_r == ST_PLAY) && i_tick && i_enable;
    assign note_end_s = count_s && (tick_cnt_r == 8'd1) && (unit_cnt_r == 5'd1);
    assign decaying_s = (decay_per_r != 3'd0) && (pitch_r != 6'd0);

    assign o_note_stb       = stb_r;
    assign o_gate           = gate_r;
    assign o_volume         = vol_r;
    assign o_phase_inc      = phase_r;
    assign o_pitch_rom_addr = addr_r;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_START;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_START:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (i_note_valid) begin
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_LOOKUP: state_nxt_s = ST_LOAD;
            ST_LOAD:   state_nxt_s = ST_PLAY;
            ST_PLAY: begin
                if (note_end_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            default:   state_nxt_s = ST_START;
        endcase
    end

    // Registered outputs, note latch and tick/unit/decay counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stb_r       <= 1'b0;
            gate_r      <= 1'b0;
            vol_r       <= 4'd0;
            phase_r     <= 16'd0;
            addr_r      <= 6'd0;
            pitch_r     <= 6'd0;
            len_r       <= 5'd0;
            decay_per_r <= 3'd0;
            tick_cnt_r  <= 8'd0;
            unit_cnt_r  <= 5'd0;
            decay_cnt_r <= 3'd0;
        end else begin
            stb_r <= 1'b0;
            case (state_r)
                ST_START: begin
                    stb_r <= 1'b1;
                end
                ST_WAIT: begin
                    if (i_note_valid) begin
                        pitch_r     <= i_note_pitch;
                        len_r       <= (i_note_len == 5'd0) ? 5'd1 : i_note_len;
                        decay_per_r <= i_note_instrument[2:0];
                        // Address is presented during LOOKUP so the ROM data
                        // lines up with the LOAD cycle.
                        addr_r      <= i_note_pitch;
                    end
                end
                ST_LOOKUP: begin
                    addr_r <= pitch_r;
                end
                ST_LOAD: begin
                    if (pitch_r != 6'd0) begin
                        phase_r <= i_pitch_rom_data;
                        gate_r  <= 1'b1;
                        vol_r   <= 4'd15;
                    end else begin
                        phase_r <= 16'd0;
                        gate_r  <= 1'b0;
                        vol_r   <= 4'd0;
                    end
                    unit_cnt_r  <= len_r;
                    tick_cnt_r  <= TPU;
                    decay_cnt_r <= decay_per_r;
                end
                ST_PLAY: begin
                    if (count_s) begin
                        if (tick_cnt_r == 8'd1) begin
                            tick_cnt_r <= TPU;
                            if (unit_cnt_r == 5'd1) begin
                                gate_r <= 1'b0;
                                stb_r  <= 1'b1;
                            end else begin
                                unit_cnt_r <= unit_cnt_r - 5'd1;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r - 8'd1;
                        end
                        if (decaying_s) begin
                            if (decay_cnt_r == 3'd1) begin
                                decay_cnt_r <= decay_per_r;
                                vol_r <= (vol_r == 4'd0) ? 4'd0 : vol_r - 4'd1;
                            end else begin
                                decay_cnt_r <= decay_cnt_r - 3'd1;
                            end
                        end else begin
                            decay_cnt_r <= decay_cnt_r;
                        end
                    end
                end
                default: begin
                    stb_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_player.sv
// ---------------------------------------------------------------------------
// tb_note_player
//   Self-checking bench for note_player (TICKS_PER_UNIT = 2). A small period
//   ROM with one-cycle latency is modelled here. Expected outputs come from
//   the note rules: a note lasts max(len,1)*TPU counted ticks, and the volume
//   after k counted ticks is 15 - k/D (floored at 0) for a pitched note with
//   D != 0, 15 for D == 0 and 0 for a rest.
// ---------------------------------------------------------------------------
module tb_note_player;

    localparam int TPU = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_tick;
    logic        i_enable;
    logic        o_note_stb;
    logic        i_note_valid;
    logic [5:0]  i_note_pitch;
    logic [4:0]  i_note_len;
    logic [3:0]  i_note_instrument;
    logic [5:0]  o_pitch_rom_addr;
    logic [15:0] i_pitch_rom_data;
    logic [15:0] o_phase_inc;
    logic        o_gate;
    logic [3:0]  o_volume;

    logic [15:0] rom [64];

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] held_phase;
    logic [3:0]  held_vol;

    typedef struct {
        logic [5:0] pitch;
        logic [4:0] len;
        logic [3:0] instr;
        int         mode;       // 0 random ticks, 1 pause 10 ticks, 2 tick every cycle
        int         exp_ticks;  // counted ticks until the note ends
        logic [3:0] exp_vol;    // volume left after the note ends
    } vec_t;

    vec_t tbl [8];

    note_player #(.TICKS_PER_UNIT(TPU)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_tick            (i_tick),
        .i_enable          (i_enable),
        .o_note_stb        (o_note_stb),
        .i_note_valid      (i_note_valid),
        .i_note_pitch      (i_note_pitch),
        .i_note_len        (i_note_len),
        .i_note_instrument (i_note_instrument),
        .o_pitch_rom_addr  (o_pitch_rom_addr),
        .i_pitch_rom_data  (i_pitch_rom_data),
        .o_phase_inc       (o_phase_inc),
        .o_gate            (o_gate),
        .o_volume          (o_volume)
    );

    always #5 i_clk = ~i_clk;

    // Period ROM, one cycle read latency.
    always_ff @(posedge i_clk) begin
        i_pitch_rom_data <= rom[o_pitch_rom_addr];
    end

    function automatic logic [21:0] outs();
        return {o_note_stb, o_gate, o_volume, o_phase_inc};
    endfunction

    function automatic logic [3:0] model_vol(input logic [5:0] pitch, input int d, input int k);
        if (pitch == 6'd0) return 4'd0;
        if (d == 0) return 4'd15;
        if (k / d >= 15) return 4'd0;
        return 4'(15 - k / d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_note_valid = 1'b0; i_tick = 1'b1; i_enable = 1'b1;
        cyc();
        check("reset_outs", {4'd0, o_pitch_rom_addr, outs()}, 32'd0);
        held_vol = 4'd0; held_phase = 16'd0;
        i_rst = 1'b0; i_tick = 1'b0;
        cyc();
        check("start_stb", 32'(outs()), {10'd0, 1'b1, 1'b0, 4'd0, 16'd0});
        cyc();
        check("start_stb_once", 32'(outs()), 32'd0);
    endtask

    task automatic run_note(input string tag, input logic [5:0] pitch, input logic [4:0] len,
                            input logic [3:0] instr, input int mode, input int total,
                            input int abort_at, output logic [3:0] vol_end);
        int          d;
        int          k;
        int          raw;
        int          cycles;
        bit          done;
        bit          tk;
        bit          en;
        logic        g;
        logic [15:0] ph;
        d = int'(instr[2:0]);
        k = 0; raw = 0; cycles = 0; done = 1'b0;
        g  = (pitch != 6'd0);
        ph = (pitch == 6'd0) ? 16'd0 : rom[pitch];

        // WAIT: present the note together with a tick that must be dropped
        i_note_valid = 1'b1; i_note_pitch = pitch; i_note_len = len; i_note_instrument = instr;
        i_tick = 1'b1; i_enable = 1'b1;
        cyc();
        check({tag, "_accept"}, 32'(outs()), {10'd0, 1'b0, 1'b0, held_vol, held_phase});
        check({tag, "_addr"}, 32'(o_pitch_rom_addr), 32'(pitch));
        // LOOKUP: stray valid with different fields must be ignored
        i_note_pitch = pitch ^ 6'h2A; i_note_len = ~len; i_note_instrument = ~instr;
        cyc();
        check({tag, "_lookup"}, 32'(outs()), {10'd0, 1'b0, 1'b0, held_vol, held_phase});
        // LOAD: coincident tick is not counted
        i_note_valid = 1'b0; i_tick = 1'b1;
        cyc();
        held_vol = model_vol(pitch, d, 0); held_phase = ph;
        check({tag, "_load"}, 32'(outs()), {10'd0, 1'b0, g, held_vol, ph});

        while (!done && cycles < 3000) begin
            case (mode)
                1: begin
                    tk = (cycles % 2 == 0);
                    en = !(tk && raw >= 2 && raw < 12);
                end
                2: begin
                    tk = 1'b1; en = 1'b1;
                end
                default: begin
                    tk = ($urandom_range(0, 2) == 0);
                    en = ($urandom_range(0, 4) != 0);
                end
            endcase
            i_tick = tk; i_enable = en;
            cyc();
            cycles++;
            if (tk) raw++;
            if (tk && en) k++;
            held_vol = model_vol(pitch, d, k);
            if (k == total) begin
                check({tag, "_end"}, 32'(outs()), {10'd0, 1'b1, 1'b0, held_vol, ph});
                done = 1'b1;
            end else begin
                check({tag, "_play"}, 32'(outs()), {10'd0, 1'b0, g, held_vol, ph});
                if (abort_at > 0 && k >= abort_at) done = 1'b1;
            end
        end
        i_tick = 1'b0; i_enable = 1'b1;
        if (!done) begin
            n_total++;
            $display("FAIL %s_timeout: counted %0d ticks, note end expected at %0d", tag, k, total);
        end
        if (mode == 1 && k == total) begin
            check({tag, "_pause_shift"}, 32'(raw), 32'(total + 10));
        end
        if (k == total) begin
            // Waiting: ticks must not re-issue the strobe or reopen the gate
            for (int i = 0; i < 3; i++) begin
                i_tick = 1'b1;
                cyc();
                check({tag, "_idle"}, 32'(outs()), {10'd0, 1'b0, 1'b0, held_vol, ph});
            end
            i_tick = 1'b0;
        end
        vol_end = held_vol;
    endtask

    initial begin
        logic [3:0] vend;
        logic [5:0] rp;
        logic [4:0] rl;
        logic [3:0] ri;
        int         rt;

        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        rom[5] = 16'h1234;
        i_rst = 1'b1; i_tick = 1'b0; i_enable = 1'b1; i_note_valid = 1'b0;
        i_note_pitch = 6'd0; i_note_len = 5'd0; i_note_instrument = 4'd0;
        held_vol = 4'd0; held_phase = 16'd0;
        repeat (3) cyc();

        do_reset();
        // No second request without a note, even with ticks arriving
        for (int i = 0; i < 6; i++) begin
            i_tick = 1'b1;
            cyc();
            check("no_restb", 32'(outs()), 32'd0);
        end
        i_tick = 1'b0;

        tbl[0] = '{6'd5,  5'd3,  4'd0,  2, 6,  4'd15};
        tbl[1] = '{6'd0,  5'd0,  4'd3,  2, 2,  4'd0};
        tbl[2] = '{6'd7,  5'd31, 4'd2,  2, 62, 4'd0};
        tbl[3] = '{6'd9,  5'd4,  4'd3,  0, 8,  4'd13};
        tbl[4] = '{6'd1,  5'd1,  4'd1,  2, 2,  4'd13};
        tbl[5] = '{6'd63, 5'd2,  4'hF,  0, 4,  4'd15};
        tbl[6] = '{6'd2,  5'd5,  4'hB,  0, 10, 4'd12};
        tbl[7] = '{6'd5,  5'd3,  4'd0,  1, 6,  4'd15};

        for (int i = 0; i < 8; i++) begin
            run_note($sformatf("vec%0d", i), tbl[i].pitch, tbl[i].len, tbl[i].instr,
                     tbl[i].mode, tbl[i].exp_ticks, 0, vend);
            check($sformatf("vec%0d_final_vol", i), 32'(o_volume), 32'(tbl[i].exp_vol));
        end

        // Reset in the middle of a note
        run_note("abort", 6'd5, 5'd10, 4'd1, 2, 20, 3, vend);
        do_reset();

        // Randomised notes against the rule-based model
        for (int i = 0; i < 12; i++) begin
            rp = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            rl = 5'($urandom_range(0, 31));
            ri = 4'($urandom);
            rt = ((rl == 5'd0) ? 1 : int'(rl)) * TPU;
            run_note($sformatf("rnd%0d", i), rp, rl, ri, 0, rt, 0, vend);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
